// File: rtl/ccta_window_accumulator.sv
// Collects CCTA results into fixed-size windows and reports sum/min/max/count/ctrl-mix per window.
// Valid/ready handshakes on both the sample input and the window result output.
module ccta_window_accumulator #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned WIN    = 4,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned SUM_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] q_in,
  input  logic              ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              mixed_out
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e              state_q, state_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ctrl_ref_q, ctrl_ref_d;
  logic                mixed_q, mixed_d;
  logic                accept;

  assign in_ready = (state_q != StDone) & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    ctrl_ref_d = ctrl_ref_q;
    mixed_d    = mixed_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sum_d      = SUM_W'(q_in);
          min_d      = q_in;
          max_d      = q_in;
          cnt_d      = CNT_W'(1);
          ctrl_ref_d = ctrl_in;
          mixed_d    = 1'b0;
          state_d    = flush ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          sum_d   = sum_q + SUM_W'(q_in);
          cnt_d   = cnt_q + CNT_W'(1);
          mixed_d = mixed_q | (ctrl_in != ctrl_ref_q);
          if (q_in < min_q) min_d = q_in;
          if (q_in > max_q) max_d = q_in;
          if (cnt_d == CNT_W'(WIN) || flush) state_d = StDone;
        end else if (flush) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Accumulators cleared on handoff so the next window starts from nothing.
        if (out_ready) begin
          state_d = StIdle;
          sum_d   = '0;
          min_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          mixed_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      ctrl_ref_q <= 1'b0;
      mixed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      ctrl_ref_q <= ctrl_ref_d;
      mixed_q    <= mixed_d;
    end
  end

  // Result bus is forced to zero unless a window is being presented.
  always_comb begin
    out_valid = (state_q == StDone);
    sum_out   = '0;
    min_out   = '0;
    max_out   = '0;
    cnt_out   = '0;
    mixed_out = 1'b0;
    if (out_valid) begin
      sum_out   = sum_q;
      min_out   = min_q;
      max_out   = max_q;
      cnt_out   = cnt_q;
      mixed_out = mixed_q;
    end
  end

endmodule
